// File: rtl/z_test_sched.sv
// z_test_sched: owns the depth-buffer memory port. Each fragment gets a
// read-compare-conditional-write depth test and returns one pass/fail result.
// Whole-buffer clears share the same port. Only one memory transaction is
// ever outstanding.
//
// Handshake rule for every valid/ready pair (frag_*, mem_req_*, res_*):
// a transfer happens on a rising clk_i edge where valid && ready are both
// high. Once valid is raised, it and its payload stay stable until that
// transfer happens.
module z_test_sched #(
    parameter int Z_SIZE       = 8,
    parameter int X_RES        = 4,
    parameter int Y_RES        = 4,
    parameter int X_PIXEL_SIZE = $clog2(X_RES),
    parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter int ADDR_SIZE    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [2:0]              z_func_i,
    input  logic [ADDR_SIZE-1:0]    base_addr_i,
    input  logic                    clear_req_i,
    input  logic [Z_SIZE-1:0]       clear_value_i,
    output logic                    clear_busy_o,
    output logic                    clear_done_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_we_o,
    output logic [ADDR_SIZE-1:0]    mem_addr_o,
    output logic [Z_SIZE-1:0]       mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [Z_SIZE-1:0]       mem_rdata_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic                    res_pass_o,
    output logic [X_PIXEL_SIZE-1:0] res_x_o,
    output logic [Y_PIXEL_SIZE-1:0] res_y_o,
    output logic [2:0]              state_o
);

    localparam int                NPIX  = X_RES * Y_RES;
    localparam int                CNT_W = $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_RESULT  = 3'd4,
        S_CLR     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [X_PIXEL_SIZE-1:0] x_q;
    logic [Y_PIXEL_SIZE-1:0] y_q;
    logic [2:0]              func_q;
    logic [ADDR_SIZE-1:0]    addr_q;
    // Holds the fragment depth during a test and the clear value during a clear.
    logic [Z_SIZE-1:0]       wdata_q;
    logic [CNT_W-1:0]        clr_cnt_q;
    logic                    pass_q;
    logic                    done_q;
    logic                    z_ok;

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign res_pass_o   = pass_q;
    assign res_x_o      = x_q;
    assign res_y_o      = y_q;
    assign clear_done_o = done_q;
    assign state_o      = state_q;

    // Depth compare: fragment depth (op) stored depth returned by the read.
    always_comb begin
        z_ok = 1'b0;
        case (func_q)
            3'd0:    z_ok = 1'b0;
            3'd1:    z_ok = (wdata_q <  mem_rdata_i);
            3'd2:    z_ok = (wdata_q <= mem_rdata_i);
            3'd3:    z_ok = (wdata_q >  mem_rdata_i);
            3'd4:    z_ok = (wdata_q >= mem_rdata_i);
            3'd5:    z_ok = (wdata_q == mem_rdata_i);
            3'd6:    z_ok = (wdata_q != mem_rdata_i);
            default: z_ok = 1'b1;
        endcase
    end

    // Next-state and handshake outputs; a clear request beats a fragment in IDLE.
    always_comb begin
        state_d         = state_q;
        frag_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        res_valid_o     = 1'b0;
        clear_busy_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                frag_ready_o = !clear_req_i && !rst_i;
                if (clear_req_i)
                    state_d = S_CLR;
                else if (frag_valid_i)
                    state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i)
                    state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i)
                    state_d = z_ok ? S_WR_REQ : S_RESULT;
            end
            S_WR_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_we_o        = 1'b1;
                if (mem_req_ready_i)
                    state_d = S_RESULT;
            end
            S_RESULT: begin
                res_valid_o = 1'b1;
                if (res_ready_i)
                    state_d = S_IDLE;
            end
            S_CLR: begin
                clear_busy_o    = 1'b1;
                mem_req_valid_o = 1'b1;
                mem_we_o        = 1'b1;
                if (mem_req_ready_i && clr_cnt_q == LAST)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Datapath: latch the job on entry, advance the clear address, record the verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q       <= '0;
            y_q       <= '0;
            func_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            clr_cnt_q <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_req_i) begin
                        clr_cnt_q <= '0;
                        addr_q    <= base_addr_i;
                        wdata_q   <= clear_value_i;
                    end else if (frag_valid_i) begin
                        x_q     <= frag_x_i;
                        y_q     <= frag_y_i;
                        func_q  <= z_func_i;
                        wdata_q <= frag_z_i;
                        addr_q  <= base_addr_i
                                 + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES)
                                 + ADDR_SIZE'(frag_x_i);
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i && !z_ok)
                        pass_q <= 1'b0;
                end
                S_WR_REQ: begin
                    if (mem_req_ready_i)
                        pass_q <= 1'b1;
                end
                S_CLR: begin
                    if (mem_req_ready_i) begin
                        if (clr_cnt_q == LAST) begin
                            done_q <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                            addr_q    <= addr_q + ADDR_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z_test_sched.sv
// Bench for z_test_sched: directed scenarios followed by randomized fragments
// and clears, checked against an address-keyed depth model and a queue of
// expected memory transactions and results.
`timescale 1ns/1ps
module tb_z_test_sched;

    logic        clk_i, rst_i;
    logic        frag_valid_i, frag_ready_o;
    logic [1:0]  frag_x_i, frag_y_i;
    logic [7:0]  frag_z_i;
    logic [2:0]  z_func_i;
    logic [31:0] base_addr_i;
    logic        clear_req_i, clear_busy_o, clear_done_o;
    logic [7:0]  clear_value_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        res_valid_o, res_ready_i, res_pass_o;
    logic [1:0]  res_x_o, res_y_o;
    logic [2:0]  state_o;

    z_test_sched dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
        .frag_x_i(frag_x_i), .frag_y_i(frag_y_i), .frag_z_i(frag_z_i),
        .z_func_i(z_func_i), .base_addr_i(base_addr_i),
        .clear_req_i(clear_req_i), .clear_value_i(clear_value_i),
        .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_pass_o(res_pass_o), .res_x_o(res_x_o), .res_y_o(res_y_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [40:0] exp_mem_q[$];          // {we, addr, wdata}
    logic [4:0]  exp_res_q[$];          // {pass, x, y}
    logic [7:0]  ref_mem[logic [31:0]]; // expected depth buffer
    logic [7:0]  mem_a[logic [31:0]];   // bench memory behind the DUT port

    int          rdy_mode;              // 0 always, 1 random, 2 toggle, 3 reads only
    int          max_rd_delay;
    bit          noise;
    bit          rd_pend;
    int          rd_dly;
    logic [31:0] rd_addr;
    bit          prev_stall;
    logic [40:0] prev_req;
    bit          frag_hs_seen, res_hs_seen, res_seen_valid, auto_drop;
    int          fhs_cyc, res_first_cyc, done_cnt, done_cyc, ready_bad, wr_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit z_rule(input logic [2:0] f, input logic [7:0] fz, input logic [7:0] sz);
        case (f)
            3'd0: return 1'b0;
            3'd1: return fz < sz;
            3'd2: return fz <= sz;
            3'd3: return fz > sz;
            3'd4: return fz >= sz;
            3'd5: return fz == sz;
            3'd6: return fz != sz;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] mem_get(input logic [31:0] a);
        return mem_a.exists(a) ? mem_a[a] : 8'h00;
    endfunction

    task automatic model_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                              input logic [2:0] f, input logic [31:0] base);
        logic [31:0] a;
        bit p;
        a = base + 32'(y) * 32'd4 + 32'(x);
        p = z_rule(f, z, ref_get(a));
        exp_mem_q.push_back({1'b0, a, 8'h00});
        if (p) begin
            exp_mem_q.push_back({1'b1, a, z});
            ref_mem[a] = z;
        end
        exp_res_q.push_back({p, x, y});
    endtask

    task automatic model_clear(input logic [7:0] v, input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            exp_mem_q.push_back({1'b1, base + 32'(i), v});
            ref_mem[base + 32'(i)] = v;
        end
    endtask

    // ---------------- monitor (runs just before each active edge) ----------------
    task automatic observe();
        logic [40:0] e;
        logic [4:0]  r;
        if (rst_i) begin
            prev_stall = 1'b0;
            return;
        end
        if (clear_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ((clear_busy_o || clear_req_i) && frag_ready_o)
            ready_bad++;
        if (prev_stall)
            check("mem_hold", 64'({mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                  64'({1'b1, prev_req}));
        if (frag_valid_i && frag_ready_o) begin
            model_frag(frag_x_i, frag_y_i, frag_z_i, z_func_i, base_addr_i);
            frag_hs_seen = 1'b1;
            fhs_cyc = cyc;
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            check("mem_expected", 64'(exp_mem_q.size() > 0), 64'd1);
            if (exp_mem_q.size() > 0) begin
                e = exp_mem_q.pop_front();
                if (e[40])
                    check("mem_wr", 64'({mem_we_o, mem_addr_o, mem_wdata_o}), 64'(e));
                else
                    check("mem_rd", 64'({mem_we_o, mem_addr_o}), 64'(e[40:8]));
            end
            if (mem_we_o) begin
                mem_a[mem_addr_o] = mem_wdata_o;
                wr_cnt++;
            end else begin
                rd_pend = 1'b1;
                rd_addr = mem_addr_o;
                rd_dly  = int'($urandom_range(max_rd_delay, 0));
            end
        end
        prev_stall = mem_req_valid_o && !mem_req_ready_i;
        prev_req   = {mem_we_o, mem_addr_o, mem_wdata_o};
        if (res_valid_o && !res_seen_valid) begin
            res_seen_valid = 1'b1;
            res_first_cyc  = cyc;
        end
        if (res_valid_o && res_ready_i) begin
            check("res_expected", 64'(exp_res_q.size() > 0), 64'd1);
            if (exp_res_q.size() > 0) begin
                r = exp_res_q.pop_front();
                check("result", 64'({res_pass_o, res_x_o, res_y_o}), 64'(r));
            end
            res_hs_seen    = 1'b1;
            res_seen_valid = 1'b0;
        end
    endtask

    // ---------------- memory responder (runs just after each active edge) ----------------
    task automatic mem_respond();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 8'($urandom);
        if (rst_i) begin
            rd_pend = 1'b0;
        end else if (rd_pend) begin
            if (rd_dly == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_get(rd_addr);
                rd_pend      = 1'b0;
            end else begin
                rd_dly--;
            end
        end else if (noise && $urandom_range(3, 0) == 0) begin
            mem_rvalid_i = 1'b1;
        end
        case (rdy_mode)
            0:       mem_req_ready_i = 1'b1;
            1:       mem_req_ready_i = 1'($urandom_range(1, 0));
            2:       mem_req_ready_i = ~mem_req_ready_i;
            default: mem_req_ready_i = !mem_we_o;
        endcase
    endtask

    // One clock: inputs already driven by the caller; drop a clear request on
    // its done pulse, observe, take the edge, then drive the memory response.
    task automatic cycle();
        #1;
        if (auto_drop && clear_done_o)
            clear_req_i = 1'b0;
        #1;
        observe();
        @(posedge clk_i);
        #1;
        cyc++;
        mem_respond();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                             input logic [2:0] f, input logic [31:0] base, input bit rnd_ready,
                             input bit clr_mid, input logic [7:0] clr_val);
        int n;
        frag_x_i = x; frag_y_i = y; frag_z_i = z; z_func_i = f; base_addr_i = base;
        frag_valid_i = 1'b1;
        frag_hs_seen = 1'b0; res_hs_seen = 1'b0; res_seen_valid = 1'b0;
        res_ready_i = 1'b0;
        n = 0;
        while (!frag_hs_seen && n < 300) begin
            cycle();
            n++;
        end
        frag_valid_i = 1'b0;
        frag_x_i = 2'($urandom); frag_y_i = 2'($urandom);
        frag_z_i = 8'($urandom); z_func_i = 3'($urandom);
        check("frag_accept", 64'(frag_hs_seen), 64'd1);
        if (clr_mid) begin
            clear_value_i = clr_val;
            clear_req_i   = 1'b1;
            model_clear(clr_val, base);
            auto_drop = 1'b1;
        end
        n = 0;
        while (!res_hs_seen && n < 300) begin
            res_ready_i = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            cycle();
            n++;
        end
        res_ready_i = 1'b0;
        check("result_seen", 64'(res_hs_seen), 64'd1);
    endtask

    task automatic wait_clear_drop(input string tag);
        int n;
        n = 0;
        while (clear_req_i && n < 300) begin
            cycle();
            n++;
        end
        check(tag, 64'(clear_req_i), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, 64'({frag_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
                        res_valid_o, res_pass_o, res_x_o, res_y_o, clear_busy_o,
                        clear_done_o, state_o}), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] bases[3];
        bases[0] = 32'h0; bases[1] = 32'h100; bases[2] = 32'hFFFF_FFF8;
        rst_i = 1'b1; frag_valid_i = 1'b0; frag_x_i = '0; frag_y_i = '0; frag_z_i = '0;
        z_func_i = '0; base_addr_i = '0; clear_req_i = 1'b0; clear_value_i = '0;
        mem_req_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0; res_ready_i = 1'b0;
        rdy_mode = 0; max_rd_delay = 0; noise = 1'b0; rd_pend = 1'b0; rd_dly = 0; rd_addr = '0;
        prev_stall = 1'b0; prev_req = '0; auto_drop = 1'b0;
        frag_hs_seen = 0; res_hs_seen = 0; res_seen_valid = 0;
        fhs_cyc = 0; res_first_cyc = 0; done_cnt = 0; done_cyc = 0; ready_bad = 0; wr_cnt = 0;

        // Reset
        repeat (3) cycle();
        check_zero_outputs("reset_outputs");
        rst_i = 1'b0;
        cycle();

        // LESS pass at (1,2), base 0x100: read/write 0x109, best-case latency 4
        mem_a[32'h109] = 8'd200; ref_mem[32'h109] = 8'd200;
        send_frag(2'd1, 2'd2, 8'd50, 3'd1, 32'h100, 1'b0, 1'b0, 8'h00);
        check("pass_latency", 64'(res_first_cyc - fhs_cyc), 64'd4);
        check("pass_mem_0x109", 64'(mem_get(32'h109)), 64'd50);

        // GREATER with equal depth fails: read only, best-case latency 3
        mem_a[32'h100] = 8'd30; ref_mem[32'h100] = 8'd30;
        send_frag(2'd0, 2'd0, 8'd30, 3'd3, 32'h100, 1'b0, 1'b0, 8'h00);
        check("fail_latency", 64'(res_first_cyc - fhs_cyc), 64'd3);
        check("fail_mem_0x100", 64'(mem_get(32'h100)), 64'd30);

        // Clear of 16 pixels with a toggling memory ready
        rdy_mode = 2; done_cnt = 0; ready_bad = 0; wr_cnt = 0;
        base_addr_i = 32'h0; clear_value_i = 8'hFF; clear_req_i = 1'b1;
        model_clear(8'hFF, 32'h0);
        auto_drop = 1'b1;
        wait_clear_drop("clear_done_seen");
        repeat (4) cycle();
        check("clear_done_count", 64'(done_cnt), 64'd1);
        check("clear_write_count", 64'(wr_cnt), 64'd16);
        check("clear_frag_ready_low", 64'(ready_bad), 64'd0);
        check("clear_queue_empty", 64'(exp_mem_q.size()), 64'd0);
        rdy_mode = 0;

        // Clear and fragment offered together: clear runs first
        done_cnt = 0;
        base_addr_i = 32'h0; clear_value_i = 8'h33; clear_req_i = 1'b1;
        model_clear(8'h33, 32'h0);
        send_frag(2'd2, 2'd3, 8'h10, 3'd2, 32'h0, 1'b0, 1'b0, 8'h00);
        check("clr_before_frag", 64'(fhs_cyc >= done_cyc && done_cnt == 1), 64'd1);
        check("clr_frag_mem", 64'(mem_get(32'd14)), 64'h10);

        // Result back-pressure: hold res_ready_i low for 5 cycles
        frag_x_i = 2'd1; frag_y_i = 2'd1; frag_z_i = 8'h77; z_func_i = 3'd7;
        base_addr_i = 32'h0; frag_valid_i = 1'b1; frag_hs_seen = 1'b0;
        res_hs_seen = 1'b0; res_ready_i = 1'b0;
        n = 0;
        while (!frag_hs_seen && n < 50) begin cycle(); n++; end
        frag_valid_i = 1'b0;
        n = 0;
        while (!res_valid_o && n < 50) begin cycle(); n++; end
        for (int i = 0; i < 5; i++) begin
            check("hold_result", 64'({res_valid_o, res_pass_o, res_x_o, res_y_o,
                                      frag_ready_o, mem_req_valid_o}),
                  64'({1'b1, exp_res_q.size() > 0 ? exp_res_q[0] : 5'h1F, 2'b00}));
            cycle();
        end
        res_ready_i = 1'b1;
        n = 0;
        while (!res_hs_seen && n < 20) begin cycle(); n++; end
        res_ready_i = 1'b0;
        check("hold_released", 64'(res_hs_seen), 64'd1);

        // Reset while a write is stalled
        rdy_mode = 3;
        a = 32'h40 + 32'd15;
        frag_x_i = 2'd3; frag_y_i = 2'd3; frag_z_i = 8'h5A; z_func_i = 3'd7;
        base_addr_i = 32'h40; frag_valid_i = 1'b1; frag_hs_seen = 1'b0;
        n = 0;
        while (!frag_hs_seen && n < 50) begin cycle(); n++; end
        frag_valid_i = 1'b0;
        n = 0;
        while (!(mem_req_valid_o && mem_we_o) && n < 50) begin cycle(); n++; end
        check("wr_stall_reached", 64'({mem_req_valid_o, mem_we_o, mem_addr_o}), 64'({2'b11, a}));
        repeat (2) cycle();
        rst_i = 1'b1;
        cycle();
        check_zero_outputs("midop_reset_outputs");
        rst_i = 1'b0;
        exp_mem_q.delete(); exp_res_q.delete();
        ref_mem.delete(a);
        rdy_mode = 0;
        cycle();
        send_frag(2'd3, 2'd3, 8'h21, 3'd3, 32'h40, 1'b0, 1'b0, 8'h00);
        check("post_reset_write", 64'(mem_get(a)), 64'h21);

        // Randomized traffic
        noise = 1'b1; max_rd_delay = 2;
        for (int t = 0; t < 80; t++) begin
            bit cm;
            logic [31:0] b;
            rdy_mode = int'($urandom_range(2, 0));
            b  = bases[$urandom_range(2, 0)];
            cm = ($urandom_range(7, 0) == 0);
            send_frag(2'($urandom), 2'($urandom), 8'($urandom_range(7, 0) * 36),
                      3'($urandom), b, 1'b1, cm, 8'($urandom_range(7, 0) * 36));
            if (cm)
                wait_clear_drop("pending_clear_done");
            if ($urandom_range(11, 0) == 0) begin
                base_addr_i = b; clear_value_i = 8'($urandom_range(7, 0) * 36);
                clear_req_i = 1'b1;
                model_clear(clear_value_i, b);
                wait_clear_drop("rand_clear_done");
            end
        end
        repeat (5) cycle();

        // Final buffer contents and drained queues
        foreach (ref_mem[k])
            check("final_mem", 64'(mem_get(k)), 64'(ref_mem[k]));
        check("final_mem_q", 64'(exp_mem_q.size()), 64'd0);
        check("final_res_q", 64'(exp_res_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/z_test_sched.md
Name: z_test_sched

Overview:
- Sequencer that owns the single depth-buffer memory port for the rasteriser.
- Accepts fragments (x, y, z) over a valid/ready handshake and performs a read-compare-conditional-write depth test for each one.
- Returns one pass/fail result per fragment.
- Also executes whole-buffer clear commands, writing a clear value to every pixel.
- Sits between the fragment generator and the depth-buffer memory, and serialises test traffic against clear traffic.

Parameters:
- Z_SIZE, 8, depth value width.
- X_RES, 4, horizontal resolution in pixels.
- Y_RES, 4, vertical resolution in pixels.
- X_PIXEL_SIZE, $clog2(X_RES), x coordinate width.
- Y_PIXEL_SIZE, $clog2(Y_RES), y coordinate width.
- ADDR_SIZE, 32, memory address width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- frag_valid_i  in  1  fragment offered.
- frag_ready_o  out  1  fragment accepted when valid&&ready.
- frag_x_i  in  X_PIXEL_SIZE  fragment x.
- frag_y_i  in  Y_PIXEL_SIZE  fragment y.
- frag_z_i  in  Z_SIZE  fragment depth.
- z_func_i  in  3  compare function: 0 NEVER, 1 LESS, 2 LEQUAL, 3 GREATER, 4 GEQUAL, 5 EQUAL, 6 NOTEQUAL, 7 ALWAYS. Compare is frag_z op stored_z.
- base_addr_i  in  ADDR_SIZE  buffer base address.
- clear_req_i  in  1  level request to clear the buffer.
- clear_value_i  in  Z_SIZE  value written during a clear.
- clear_busy_o  out  1  high while a clear is in progress.
- clear_done_o  out  1  one-cycle pulse after the last clear write.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory request accepted.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_SIZE  request address.
- mem_wdata_o  out  Z_SIZE  write data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  Z_SIZE  read data.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumed when valid&&ready.
- res_pass_o  out  1  depth test passed.
- res_x_o  out  X_PIXEL_SIZE  x of the result.
- res_y_o  out  Y_PIXEL_SIZE  y of the result.

Behaviour:
- Reset: state IDLE. All outputs 0: frag_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, res_valid_o, res_pass_o, res_x_o, res_y_o, clear_busy_o, clear_done_o. Clear counter 0.
- Reset mid-operation aborts any transaction with no drain; the memory side is reset with the same rst_i.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESULT, CLR.
- IDLE:
  - frag_ready_o = 1 only in IDLE with clear_req_i = 0 (combinational).
  - If clear_req_i = 1, go to CLR. Clear takes priority over a simultaneously offered fragment.
  - Else on a fragment handshake: latch x, y, z; latch z_func_i and base_addr_i; go to RD_REQ.
- Address: base + y*X_RES + x, computed in ADDR_SIZE bits with modulo-2^ADDR_SIZE wrap. Registered, so mem_addr_o is stable while mem_req_valid_o = 1.
- RD_REQ: mem_req_valid_o = 1, mem_we_o = 0. On mem_req_ready_i go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid_i, compare against mem_rdata_i.
  - Pass: go to WR_REQ.
  - Fail: set res_pass_o = 0 and go to RESULT.
  - mem_rvalid_i outside RD_WAIT is ignored.
- WR_REQ: mem_req_valid_o = 1, mem_we_o = 1, mem_wdata_o = latched z. On mem_req_ready_i set res_pass_o = 1 and go to RESULT.
- RESULT:
  - res_valid_o = 1; res_x_o, res_y_o, res_pass_o held stable.
  - On res_ready_i go to IDLE.
  - Best-case latency: accept cycle N, read request at N+1. With a 0-wait memory and rvalid at N+2, the fail result is valid at N+3 and the pass result at N+4.
- NEVER: the read is still issued; the result is always fail and no write occurs. ALWAYS: always writes.
- CLR:
  - clear_busy_o = 1. Latch clear_value_i and base_addr_i on entry.
  - Issue writes to base+0 .. base+X_RES*Y_RES-1 in order, one per mem handshake. The counter advances only on mem_req_ready_i; mem_req_valid_o stays high across stalls.
  - After the last accepted write: clear_done_o pulses for 1 cycle, clear_busy_o deasserts, go to IDLE.
  - If clear_req_i is still high in IDLE, a new clear starts. The requester drops the request on clear_done_o.
- clear_req_i asserted while a fragment is in flight is held pending; it takes effect in IDLE after the result handshake.
- Exactly one memory transaction is outstanding at any time.

Test Plan:
- Reset, then stored 200 at (1,2) with base 0x100, LESS, frag z=50: read addr 0x109, write 50 to 0x109, res_pass_o=1, res_x_o=1, res_y_o=2.
- Stored 30 at (0,0), GREATER, frag z=30: read only, no write request, res_pass_o=0.
- clear_req_i with clear_value_i=0xFF, base 0x0, mem_req_ready_i toggling 1/0: exactly 16 writes to addresses 0..15 with data 0xFF. clear_done_o pulses once; frag_ready_o=0 throughout.
- clear_req_i and frag_valid_i asserted together in IDLE: clear runs first, then the fragment is accepted after clear_done_o.
- res_ready_i held low for 5 cycles: result held stable, frag_ready_o=0, no memory requests issued.
- rst_i asserted during WR_REQ stalled by mem_req_ready_i=0: next cycle all outputs 0, state IDLE, and the next fragment is processed normally.
